// File: rtl/oc8051_ifetch_q_pkg.sv
// Shared fetch-queue constants and types for the oc8051 instruction fetch path.
package oc8051_defines;

    localparam int QDEPTH     = 8;
    localparam int ROM_WORD_W = 32;
    localparam int WORD_BYTES = ROM_WORD_W / 8;

    localparam logic [15:0] FETCH_ALIGN_MASK = 16'hFFFC;

    typedef logic [$clog2(QDEPTH)-1:0] qptr_t;
    typedef logic [$clog2(QDEPTH):0]   qcnt_t;
    typedef logic [QDEPTH-1:0][7:0]    qbytes_t;

    // A read may issue only while a whole word still fits behind the queued bytes.
    localparam qcnt_t ISSUE_MAX_OCC = qcnt_t'(QDEPTH - WORD_BYTES);
    localparam qcnt_t VALID_MIN_OCC = qcnt_t'(3);

    function automatic logic [15:0] fetch_align(input logic [15:0] addr);
        return addr & FETCH_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/oc8051_ifq_align.sv
// Read-pointer byte select: presents the three bytes at the head of the fetch queue.
module oc8051_ifq_align
    import oc8051_defines::*;
(
    input  qbytes_t    q_bytes_i,
    input  qptr_t      rd_ptr_i,
    input  logic       valid_i,
    output logic [7:0] op1_o,
    output logic [7:0] op2_o,
    output logic [7:0] op3_o
);

    // NOTE: every output gets a default before the conditional, so no latch is inferred.
    always_comb begin
        op1_o = 8'h00;
        op2_o = 8'h00;
        op3_o = 8'h00;
        if (valid_i) begin
            op1_o = q_bytes_i[rd_ptr_i];
            op2_o = q_bytes_i[qptr_t'(rd_ptr_i + qptr_t'(1))];
            op3_o = q_bytes_i[qptr_t'(rd_ptr_i + qptr_t'(2))];
        end
    end

endmodule

// File: rtl/oc8051_ifetch_q.sv
// oc8051 instruction fetch queue: 32-bit ROM words into an 8-byte circular
// byte queue, exposing three opcode bytes at op_pc to the decoder.
module oc8051_ifetch_q
    import oc8051_defines::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [15:0]           rom_addr,
    input  logic [ROM_WORD_W-1:0] rom_data,
    input  logic                  ea_int,
    input  logic                  pc_load,
    input  logic [15:0]           pc_new,
    input  logic                  consume,
    input  logic [1:0]            consume_len,
    output logic                  op_valid,
    output logic [7:0]            op1,
    output logic [7:0]            op2,
    output logic [7:0]            op3,
    output logic [15:0]           op_pc,
    output logic                  ext_stall
);

    qbytes_t     buf_q, buf_d;
    qptr_t       rd_ptr_q, rd_ptr_d;
    qcnt_t       count_q, count_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [15:0] op_pc_q, op_pc_d;
    logic        inflight_q, inflight_d;
    logic        stall_q, stall_d;
    logic [1:0]  drop_q, drop_d;

    logic        op_valid_w;
    logic        capture, cap_ok, accept, issue;
    qcnt_t       n_add, n_del;
    qptr_t       wr_base;

    always_comb begin
        op_valid_w = (count_q >= VALID_MIN_OCC);
        // pc_load wins: a word returning on the load edge is stale and dropped.
        capture    = inflight_q & ~pc_load;
        cap_ok     = capture & ea_int;
        accept     = consume & op_valid_w & (consume_len != 2'd0) & ~pc_load;
        n_add      = cap_ok ? (qcnt_t'(WORD_BYTES) - qcnt_t'(drop_q)) : '0;
        n_del      = accept ? qcnt_t'(consume_len) : '0;
        wr_base    = rd_ptr_q + qptr_t'(count_q);

        buf_d = buf_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (cap_ok && (i >= int'(drop_q)))
                buf_d[qptr_t'(wr_base + qptr_t'(i) - qptr_t'(drop_q))] = rom_data[8*i +: 8];
        end

        count_d    = count_q + n_add - n_del;
        rd_ptr_d   = rd_ptr_q + qptr_t'(n_del);
        op_pc_d    = op_pc_q + 16'(n_del);
        stall_d    = stall_q | (capture & ~ea_int);
        drop_d     = capture ? 2'd0 : drop_q;
        issue      = (count_d <= ISSUE_MAX_OCC) & ~stall_d;
        inflight_d = issue;
        rom_addr_d = issue ? rom_addr_q + 16'(WORD_BYTES) : rom_addr_q;

        if (pc_load) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            op_pc_d    = pc_new;
            stall_d    = 1'b0;
            drop_d     = pc_new[1:0];
            inflight_d = 1'b0;
            rom_addr_d = fetch_align(pc_new);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rom_addr_q <= '0;
            op_pc_q    <= '0;
            inflight_q <= 1'b0;
            stall_q    <= 1'b0;
            drop_q     <= 2'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rom_addr_q <= rom_addr_d;
            op_pc_q    <= op_pc_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: the byte store is deliberately not reset; count_q gates every read of it
    // and the aligner forces zeros while fewer than three bytes are queued.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    oc8051_ifq_align u_align (
        .q_bytes_i (buf_q),
        .rd_ptr_i  (rd_ptr_q),
        .valid_i   (op_valid_w),
        .op1_o     (op1),
        .op2_o     (op2),
        .op3_o     (op3)
    );

    assign rom_addr  = rom_addr_q;
    assign op_valid  = op_valid_w;
    assign op_pc     = op_pc_q;
    assign ext_stall = stall_q;

endmodule

// File: tb/tb_oc8051_ifetch_q.sv
// Scoreboard bench for oc8051_ifetch_q: a byte-stream reference model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_oc8051_ifetch_q;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        ea_int;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        consume;
    logic [1:0]  consume_len;
    logic        op_valid;
    logic [7:0]  op1, op2, op3;
    logic [15:0] op_pc;
    logic        ext_stall;

    oc8051_ifetch_q dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ea_int      (ea_int),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .consume     (consume),
        .consume_len (consume_len),
        .op_valid    (op_valid),
        .op1         (op1),
        .op2         (op2),
        .op3         (op3),
        .op_pc       (op_pc),
        .ext_stall   (ext_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM contents: low page reads back its own address byte, other pages are scrambled.
    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [7:0] h;
        h = a[15:8];
        return a[7:0] ^ h ^ {h[4:0], h[7:5]};
    endfunction

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
    endfunction

    logic [15:0] rom_sample;
    logic        poison;
    always @(posedge clk) rom_sample <= rom_addr;
    assign rom_data = poison ? 32'hDEADBEEF : rom_word(rom_sample);

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [7:0]  b1, b2, b3;
        logic [15:0] addr;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the queue always holds m_occ consecutive ROM bytes starting at m_pc.
    int          m_occ;
    int          m_drop;
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    bit          m_infl;
    bit          m_stall;

    task automatic model_reset();
        m_occ   = 0;
        m_drop  = 0;
        m_pc    = 16'h0000;
        m_addr  = 16'h0000;
        m_infl  = 1'b0;
        m_stall = 1'b0;
    endtask

    task automatic model_edge(input bit pl, input logic [15:0] pn, input bit cs,
                              input logic [1:0] ln, input bit ea, output exp_t e);
        int add;
        int del;
        bit was_valid;
        was_valid = (m_occ >= 3);
        if (pl) begin
            m_occ   = 0;
            m_pc    = pn;
            m_addr  = {pn[15:2], 2'b00};
            m_infl  = 1'b0;
            m_stall = 1'b0;
            m_drop  = int'(pn[1:0]);
        end else begin
            add = 0;
            if (m_infl) begin
                if (ea) add = 4 - m_drop;
                else    m_stall = 1'b1;
                m_drop = 0;
            end
            del    = (cs && was_valid && ln != 2'd0) ? int'(ln) : 0;
            m_occ  = m_occ + add - del;
            m_pc   = m_pc + 16'(del);
            m_infl = (m_occ <= 4) && !m_stall;
            if (m_infl) m_addr = m_addr + 16'd4;
        end
        e.valid = (m_occ >= 3);
        e.pc    = m_pc;
        e.b1    = rom_byte(m_pc);
        e.b2    = rom_byte(m_pc + 16'd1);
        e.b3    = rom_byte(m_pc + 16'd2);
        e.addr  = m_addr;
        e.stall = m_stall;
    endtask

    task automatic step(input bit pl, input logic [15:0] pn, input bit cs,
                        input logic [1:0] ln, input bit ea, input bit pz);
        exp_t e;
        pc_load     = pl;
        pc_new      = pn;
        consume     = cs;
        consume_len = ln;
        ea_int      = ea;
        poison      = pz;
        model_edge(pl, pn, cs, ln, ea, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("op_valid",  32'(op_valid),  32'(mon_e.valid));
            check("op_pc",     32'(op_pc),     32'(mon_e.pc));
            check("rom_addr",  32'(rom_addr),  32'(mon_e.addr));
            check("ext_stall", 32'(ext_stall), 32'(mon_e.stall));
            if (mon_e.valid) begin
                check("op1", 32'(op1), 32'(mon_e.b1));
                check("op2", 32'(op2), 32'(mon_e.b2));
                check("op3", 32'(op3), 32'(mon_e.b3));
            end
        end
    end

    task automatic reset_checks();
        check("rst_op_valid",  32'(op_valid),  32'h0);
        check("rst_op_pc",     32'(op_pc),     32'h0);
        check("rst_rom_addr",  32'(rom_addr),  32'h0);
        check("rst_ext_stall", 32'(ext_stall), 32'h0);
        check("rst_op1",       32'(op1),       32'h0);
        check("rst_op2",       32'(op2),       32'h0);
        check("rst_op3",       32'(op3),       32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst         = 1'b1;
        pc_load     = 1'b0;
        consume     = 1'b0;
        consume_len = 2'd0;
        poison      = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit          pl, prev_pl;
        logic [15:0] pn;
        rst         = 1'b1;
        pc_load     = 1'b0;
        pc_new      = 16'h0000;
        consume     = 1'b0;
        consume_len = 2'd0;
        ea_int      = 1'b1;
        poison      = 1'b0;
        model_reset();
        do_reset();

        // Stream from reset with one byte consumed every cycle.
        repeat (24) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);

        // Unaligned load: first word drops three bytes.
        step(1'b1, 16'h0123, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 16'h0,    1'b0, 2'd0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 16'h0, 1'b1, 2'd2, 1'b1, 1'b0);

        // Load while a read is in flight, with the stale word poisoned.
        for (int k = 0; k < 12 && !m_infl; k++) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);
        step(1'b1, 16'h2001, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 16'h0,    1'b0, 2'd0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 16'h0, 1'b1, 2'd3, 1'b1, 1'b0);

        // External word: stall, drain the queue, then recover with a load.
        for (int k = 0; k < 12 && !m_infl; k++) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 2'd1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);
        step(1'b1, 16'h0040, 1'b0, 2'd0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);

        // Wrap at the top of the address space.
        step(1'b1, 16'hFFFE, 1'b0, 2'd0, 1'b1, 1'b1);
        step(1'b0, 16'h0,    1'b0, 2'd0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 2'd3, 1'b1, 1'b0);
        repeat (6) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);

        // Random traffic.
        prev_pl = 1'b0;
        repeat (600) begin
            pl = ($urandom_range(0, 15) == 0);
            pn = 16'($urandom);
            step(pl, pn, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 39) != 0), pl | prev_pl);
            prev_pl = pl;
        end

        // Reset in the middle of traffic.
        do_reset();
        repeat (10) step(1'b0, 16'h0, 1'b1, 2'd1, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/oc8051_ifetch_q.md
OC8051_IFETCH_Q -- requirements
Module: oc8051_ifetch_q

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rom_addr  output  16  byte address of next ROM word; bits[1:0] always 00.
REQ-004 rom_data  input  32  ROM word, valid the cycle after rom_addr is sampled; byte A+n on bits [8n+7:8n].
REQ-005 ea_int  input  1  high = word on rom_data is from internal ROM; aligned with rom_data.
REQ-006 pc_load  input  1  load new fetch PC and flush the queue.
REQ-007 pc_new  input  16  target PC for pc_load.
REQ-008 consume  input  1  decoder takes consume_len bytes this cycle.
REQ-009 consume_len  input  2  bytes consumed, 1..3; 0 = no consume.
REQ-010 op_valid  output  1  op1..op3 hold 3 valid bytes starting at op_pc.
REQ-011 op1, op2, op3  output  8 each  bytes at op_pc, op_pc+1, op_pc+2.
REQ-012 op_pc  output  16  address of op1.
REQ-013 ext_stall  output  1  fetch halted; non-internal word returned.

Function
REQ-014 The block SHALL hold an 8-byte circular byte queue with a 4-bit occupancy count (0..8).
REQ-015 A ROM read is issued at an edge when post-edge occupancy <= 4 and ext_stall is 0; rom_addr then advances by 4 (0xFFFC wraps to 0x0000).
REQ-016 A read issued at edge Ek SHALL be captured at Ek+1; at most one read in flight.
REQ-017 op_valid SHALL be 1 exactly when occupancy >= 3; op1..op3 are undefined when op_valid is 0.
REQ-018 consume with op_valid=1 and len 1..3 SHALL remove len bytes at the edge and add len to op_pc mod 2^16.
REQ-019 consume with op_valid=0 or len=0 SHALL be ignored.
REQ-020 Capture and consume in the same edge SHALL both apply; occupancy = old + 4 - len.
REQ-021 pc_load SHALL override capture and consume at that edge:
- occupancy -> 0; op_pc -> pc_new
- rom_addr -> {pc_new[15:2],2'b00}; ext_stall -> 0
- any in-flight word discarded
- first captured word drops its low pc_new[1:0] bytes
REQ-022 Timing after pc_load at E0: first word captured at E2, second at E3.
- op_valid after E2 if pc_new[1:0] <= 1, else after E3.
REQ-023 A word captured with ea_int=0 SHALL be discarded; ext_stall -> 1 and stays 1 until pc_load or rst.
- No reads issue while ext_stall=1.
- Bytes already queued remain consumable.
REQ-024 Occupancy SHALL never exceed 8 or go negative.

Reset
REQ-025 While rst=1, hold:
- occupancy 0, op_valid 0, op1..op3 0
- op_pc 0, rom_addr 0, ext_stall 0
- no read in flight
REQ-026 After rst deasserts, the first read (address 0) SHALL issue at the first rising edge.
REQ-027 rst asserted mid-operation SHALL discard queue contents and the in-flight word immediately.

Structure
REQ-028 Shared package oc8051_defines SHALL hold the queue depth (8), the ROM word width (32) and the fetch alignment mask.
REQ-029 A sub-module oc8051_ifq_align SHALL contain the combinational read-pointer byte-select producing op1..op3.

Verification
REQ-030 Reset release, ROM returns bytes 0x00,0x01,... ->
- rom_addr 0x0000 then 0x0004
- op_valid after the 2nd edge; op1/op2/op3 = 00/01/02, op_pc=0
REQ-031 Continuous consume_len=1 from reset ->
- op_pc increments every cycle
- no op_valid gaps after first valid
- occupancy never >8
REQ-032 pc_load pc_new=0x0123 ->
- rom_addr 0x0120, then 0x0124
- op_valid 3 cycles after load; op1=byte 0x0123, op_pc=0x0123
REQ-033 pc_load while a read is in flight, stale data 0xDEADBEEF ->
- stale word never appears on op1..op3
REQ-034 Word returned with ea_int=0 ->
- ext_stall=1, rom_addr frozen
- queued bytes drain; op_valid drops below 3 bytes
- pc_load clears ext_stall
REQ-035 pc_load pc_new=0xFFFE ->
- reads 0xFFFC then 0x0000
- op1/op2/op3 = bytes FFFE/FFFF/0000; consume 3 gives op_pc=0x0001
